seq_restoring_divider: RTL and testbench

//  Multi-cycle integer divider; inverse of the CLA adder datapath. Each step is a trial subtraction

---
 rtl/cpu_div_pkg.sv | 30 +++
 rtl/cla_subtractor.sv | 89 ++++++++
 rtl/seq_restoring_divider.sv | 231 +++++++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_div_pkg.sv
// ---------------------------------------------------------------------------
// cpu_div_pkg
//
// Purpose:
//     Shared definitions for the sequential restoring divider: the FSM state
//     encoding, the step-counter width helper and the quotient fill value
//     returned on a divide by zero.
//
// Contents:
//     div_state_e        DIV_IDLE / DIV_CALC / DIV_DONE
//     div_cnt_width()    step-counter width for a given operand width
//     DIV_ZERO_Q_BIT     bit replicated across the quotient on divide by zero
// ---------------------------------------------------------------------------
package cpu_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // The counter must be able to hold WIDTH itself, hence the extra bit.
    function automatic int div_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    // Divide by zero yields an all-ones quotient for both signed and unsigned.
    localparam logic DIV_ZERO_Q_BIT = 1'b1;

endpackage : cpu_div_pkg

// File: rtl/cla_subtractor.sv
// ---------------------------------------------------------------------------
// cla_subtractor
//
// Purpose:
//     Carry-lookahead subtractor computing a - b as a + ~b + 1. Bits are split
//     into GROUPSIZE-wide lookahead groups; group generate/propagate terms
//     produce the group carries, and each group then resolves its own bit
//     carries from its group carry-in. If WIDTH is not a multiple of
//     GROUPSIZE the operands are padded up to a whole number of groups.
//
// Parameters:
//     WIDTH      operand width in bits
//     GROUPSIZE  lookahead group width (1, 2, 4 or 8)
//
// Ports:
//     a       in   WIDTH  minuend
//     b       in   WIDTH  subtrahend
//     diff    out  WIDTH  a - b (modulo 2^WIDTH)
//     borrow  out  1      1 when a < b (inverse of the adder carry out)
// ---------------------------------------------------------------------------
module cla_subtractor #(
    parameter int WIDTH     = 33,
    parameter int GROUPSIZE = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NGROUPS = (WIDTH + GROUPSIZE - 1) / GROUPSIZE;
    localparam int PW      = NGROUPS * GROUPSIZE;

    logic [PW-1:0]      a_p;
    logic [PW-1:0]      b_inv;
    logic [PW-1:0]      gen;
    logic [PW-1:0]      prop;
    logic [PW-1:0]      sum_p;
    logic [NGROUPS-1:0] grp_g;
    logic [NGROUPS-1:0] grp_p;
    logic [NGROUPS:0]   grp_c;

    // Pad bits of a are 0 and of ~b are 1, so they only propagate the carry
    // out of the real top bit up to the final group carry.
    assign a_p   = PW'(a);
    assign b_inv = ~(PW'(b));
    assign gen   = a_p & b_inv;
    assign prop  = a_p ^ b_inv;

    always_comb begin
        logic gg;
        logic gp;
        logic cc;
        grp_g    = '0;
        grp_p    = '0;
        grp_c    = '0;
        sum_p    = '0;
        grp_c[0] = 1'b1;
        for (int k = 0; k < NGROUPS; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < GROUPSIZE; i++) begin
                gg = gen[k*GROUPSIZE+i] | (prop[k*GROUPSIZE+i] & gg);
                gp = gp & prop[k*GROUPSIZE+i];
            end
            grp_g[k]   = gg;
            grp_p[k]   = gp;
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
        for (int k = 0; k < NGROUPS; k++) begin
            cc = grp_c[k];
            for (int i = 0; i < GROUPSIZE; i++) begin
                sum_p[k*GROUPSIZE+i] = prop[k*GROUPSIZE+i] ^ cc;
                cc = gen[k*GROUPSIZE+i] | (prop[k*GROUPSIZE+i] & cc);
            end
        end
    end

    assign diff   = sum_p[WIDTH-1:0];
    assign borrow = ~grp_c[NGROUPS];

    generate
        if (PW > WIDTH) begin : g_pad
            logic [PW-WIDTH-1:0] unused_sum_pad;
            assign unused_sum_pad = sum_p[PW-1:WIDTH];
        end
    endgenerate

endmodule : cla_subtractor

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//
// Purpose:
//     Multi-cycle restoring integer divider with valid/ready handshakes on
//     both sides. One quotient bit is produced per cycle by a trial
//     subtraction through a carry-lookahead subtractor.
//
// Configuration:
//     DIV_SIGNED_EN  defined   : is_signed selects two's-complement division
//                                (magnitudes on entry, sign fix-up at the end)
//                    undefined : every operation is unsigned, is_signed ignored
//
// Parameters:
//     WIDTH      operand/result width (power of 2, >= 4)
//     GROUPSIZE  lookahead group width of the trial subtractor
//
// Ports:
//     clk          in   1      clock, rising edge
//     rst          in   1      synchronous reset, active-high
//     in_valid     in   1      operands valid
//     in_ready     out  1      divider idle, operands can be accepted
//     dividend     in   WIDTH  numerator
//     divisor      in   WIDTH  denominator
//     is_signed    in   1      two's-complement operation when set
//     out_valid    out  1      result valid, held until out_ready
//     out_ready    in   1      consumer takes result
//     quotient     out  WIDTH  quotient
//     remainder    out  WIDTH  remainder (sign follows dividend)
//     div_by_zero  out  1      result came from a zero divisor
// ---------------------------------------------------------------------------
module seq_restoring_divider
    import cpu_div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int GROUPSIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW        = div_cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             divisor_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic             unused_diff_msb;

    assign in_ready     = (state_q == DIV_IDLE);
    assign out_valid    = (state_q == DIV_DONE);
    assign accept       = in_valid & in_ready;
    assign divisor_zero = (divisor == '0);

    // The quotient register starts out holding the dividend; its MSB is the
    // next dividend bit to bring down into the partial remainder.
    assign trial_a = {rem_q, quo_q[WIDTH-1]};

    cla_subtractor #(
        .WIDTH     (WIDTH + 1),
        .GROUPSIZE (GROUPSIZE)
    ) u_trial_sub (
        .a      (trial_a),
        .b      ({1'b0, dvsr_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // On a borrow the shifted remainder is below the divisor, so its top bit
    // is zero and dropping it loses nothing; without a borrow the difference
    // is below the divisor and likewise fits in WIDTH bits.
    assign step_rem        = trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    assign step_quo        = {quo_q[WIDTH-2:0], ~trial_borrow};
    assign unused_diff_msb = trial_diff[WIDTH];

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic dividend_neg;
    logic divisor_neg;
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign dividend_neg = is_signed & dividend[WIDTH-1];
    assign divisor_neg  = is_signed & divisor[WIDTH-1];

    // The most negative value maps onto itself, which as an unsigned
    // magnitude is exactly right, so no overflow special case is needed.
    assign dividend_mag = dividend_neg ? (~dividend + ONE) : dividend;
    assign divisor_mag  = divisor_neg  ? (~divisor  + ONE) : divisor;
    assign q_final      = neg_quo_q ? (~step_quo + ONE) : step_quo;
    assign r_final      = neg_rem_q ? (~step_rem + ONE) : step_rem;

    // Sign fix-up flags are captured with the operands because the inputs
    // are free to change once the operation has been accepted.
    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (accept && !divisor_zero) begin
            neg_quo_d = dividend_neg ^ divisor_neg;
            neg_rem_d = dividend_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign dividend_mag     = dividend;
    assign divisor_mag      = divisor;
    assign q_final          = step_quo;
    assign r_final          = step_rem;
`endif

    // Next-state and datapath: a zero divisor skips straight to DONE, any
    // other operation runs exactly WIDTH trial steps, the last of which
    // also applies the sign fix-up and loads the result registers.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    if (divisor_zero) begin
                        quotient_d  = {WIDTH{DIV_ZERO_Q_BIT}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DIV_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = dividend_mag;
                        dvsr_d  = divisor_mag;
                        count_d = '0;
                        dbz_d   = 1'b0;
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + CNT_ONE;
                if (count_q == LAST_STEP) begin
                    quotient_d  = q_final;
                    remainder_d = r_final;
                    count_d     = '0;
                    state_d     = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (out_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Scoreboard bench for seq_restoring_divider (WIDTH=32). Stimulus pushes the
// hand-computed result for each accepted operation; a monitor on the falling
// edge checks latency when out_valid rises and pops/compares the result on
// each output handshake. Expected values for signed operations depend on
// whether DIV_SIGNED_EN is defined.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

    localparam int WIDTH = 32;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             is_signed = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] dividend  = '0;
    logic [WIDTH-1:0] divisor   = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    logic prev_valid = 1'b0;

    seq_restoring_divider #(
        .WIDTH     (WIDTH),
        .GROUPSIZE (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock and cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison helper shared by the monitor and the directed checks.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one operation at the next opportunity and, when tracked, push its
    // expected result. Returns just after the accepting edge.
    task automatic applyStimulus(input string name, input logic [31:0] a,
                                 input logic [31:0] b, input logic sg,
                                 input logic [31:0] eq, input logic [31:0] er,
                                 input logic edbz, input int elat, input bit track);
        exp_t e;
        int   waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: in_ready timeout", name);
        end else begin
            dividend  = a;
            divisor   = b;
            is_signed = sg;
            in_valid  = 1'b1;
            @(posedge clk); #1;
            if (track) begin
                e.name = name;
                e.q    = eq;
                e.r    = er;
                e.dbz  = edbz;
                e.lat  = elat;
                e.acc  = cyc;
                sb.push_back(e);
            end
            in_valid  = 1'b0;
            dividend  = 32'hDEAD_BEEF;
            divisor   = 32'h0000_0003;
            is_signed = 1'b0;
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, result on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_result: got q=0x%08h, expected none", quotient);
                end else begin
                    checkOutput({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc + 1),
                                32'(sb[0].lat));
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput({e.name, "_q"}, quotient, e.q);
                checkOutput({e.name, "_r"}, remainder, e.r);
                checkOutput({e.name, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
            end
            prev_valid = out_valid;
        end
    end

    // Wait until every pushed result has been consumed.
    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || !in_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_quotient", quotient, 32'h0);
        checkOutput("reset_remainder", remainder, 32'h0);
        checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors; back-to-back with out_ready held high.
        applyStimulus("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b1);
`ifdef DIV_SIGNED_EN
        applyStimulus("s_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 1'b1);
        applyStimulus("s_7_m2", 32'h7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h1, 1'b0, 33, 1'b1);
        applyStimulus("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 33, 1'b1);
`else
        applyStimulus("s_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, 32'h7FFF_FFFC, 32'h1, 1'b0, 33, 1'b1);
        applyStimulus("s_7_m2", 32'h7, 32'hFFFF_FFFE, 1'b1, 32'h0, 32'h7, 1'b0, 33, 1'b1);
        applyStimulus("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0, 33, 1'b1);
`endif
        applyStimulus("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 1'b0, 33, 1'b1);
        applyStimulus("u_div0", 32'h1234, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, 1'b1);
        applyStimulus("s_div0", 32'hFFFF_FFFB, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 1'b1);
        applyStimulus("u_max_1", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 33, 1'b1);
        applyStimulus("u_small", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33, 1'b1);
        drain();

        // Back-pressure: hold the result while new operands are offered.
        out_ready = 1'b0;
        applyStimulus("bp_1000_10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = 32'd5;
            divisor  = 32'd1;
            checkOutput("bp_hold_q", quotient, 32'd100);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_after_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_after_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("bp_ignored_in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a calculation abandons it.
        applyStimulus("rst_victim", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b0);
        repeat (15) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_quotient", quotient, 32'h0);
        @(posedge clk); #1;
        applyStimulus("post_rst", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0, 33, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_seq_restoring_divider
